// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the digit-entry buffer and its Horner converter.
package digit_entry_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    RADIX_HEX = 1'b0,
    RADIX_DEC = 1'b1
  } radix_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } conv_state_e;

  localparam digit_t DEC_MAX = 4'd9;

  function automatic logic [4:0] radix_val(input radix_e r);
    return (r == RADIX_DEC) ? 5'd10 : 5'd16;
  endfunction

endpackage

// File: rtl/horner_step.sv
// One Horner iteration: acc_out = acc_in * radix + digit, flagging results that exceed W bits.
module horner_step
  import digit_entry_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W+3:0] acc_in,
  input  digit_t       digit,
  input  radix_e       radix,
  output logic [W+3:0] acc_out,
  output logic         ovf
);

  // Four extra bits cover acc_in * 16 + 15 without wrapping.
  logic [W+7:0] full;

  always_comb begin
    full    = {4'd0, acc_in} * {{(W + 3){1'b0}}, radix_val(radix)} + {{(W + 4){1'b0}}, digit};
    acc_out = full[W+3:0];
    ovf     = |full[W+7:W];
  end

endmodule

// File: rtl/digit_entry_buffer.sv
// Digit-entry buffer with push/backspace/clear editing and a multi-cycle radix converter.
module digit_entry_buffer
  import digit_entry_pkg::*;
#(
  parameter int unsigned NDIG = 4,
  parameter int unsigned W    = 16,
  localparam int unsigned CW  = $clog2(NDIG + 1),
  localparam int unsigned DW  = 4 * NDIG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          del,
  input  logic          clr,
  input  logic          mode,
  input  logic [3:0]    din,
  output logic [DW-1:0] digits,
  output logic [CW-1:0] count,
  output logic [W-1:0]  value,
  output logic          valid,
  output logic          busy,
  output logic          ovf,
  output logic          err
);

  localparam logic [CW-1:0] FullCnt = CW'(NDIG);

  logic [DW-1:0]  digits_q, digits_d, base_dig, shifted;
  logic [CW-1:0]  count_q, count_d, base_cnt;
  logic [CW-1:0]  idx_q, idx_d;
  logic [W+3:0]   acc_q, acc_d, step_acc;
  logic [W-1:0]   value_q, value_d;
  logic           mode_q, valid_q, valid_d, ovf_q, ovf_d, err_q, err_d;
  logic           ovf_acc_q, ovf_acc_d, step_ovf;
  logic           mode_chg, has_hex, dec_clear, edit_ok, change;
  conv_state_e    state_q, state_d;

  horner_step #(
    .W (W)
  ) u_step (
    .acc_in  (acc_q),
    .digit   (digits_q[idx_q*4 +: 4]),
    .radix   (radix_e'(mode_q)),
    .acc_out (step_acc),
    .ovf     (step_ovf)
  );

  // Edit path: a radix switch is applied first, then the highest-priority edit against it.
  always_comb begin
    mode_chg = (mode != mode_q);
    has_hex  = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (digits_q[4*i +: 4] > DEC_MAX) has_hex = 1'b1;
    end
    dec_clear = mode_chg && mode && has_hex;
    base_dig  = dec_clear ? '0 : digits_q;
    base_cnt  = dec_clear ? '0 : count_q;
    shifted   = base_dig << 4;
    shifted[3:0] = din;

    digits_d = base_dig;
    count_d  = base_cnt;
    err_d    = dec_clear;
    edit_ok  = 1'b0;
    if (clr) begin
      digits_d = '0;
      count_d  = '0;
      edit_ok  = 1'b1;
    end else if (del) begin
      if (base_cnt != '0) begin
        digits_d = base_dig >> 4;
        count_d  = base_cnt - 1'b1;
        edit_ok  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (push) begin
      if (base_cnt < FullCnt && (!mode || din <= DEC_MAX)) begin
        digits_d = shifted;
        count_d  = base_cnt + 1'b1;
        edit_ok  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    change = edit_ok || mode_chg;
  end

  // Converter: any buffer/mode change restarts from the MSD of the new buffer.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    ovf_acc_d = ovf_acc_q;
    value_d   = value_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    if (change) begin
      if (count_d == '0) begin
        value_d = '0;
        ovf_d   = 1'b0;
        valid_d = 1'b1;
        state_d = IDLE;
      end else begin
        acc_d     = '0;
        idx_d     = count_d - 1'b1;
        ovf_acc_d = 1'b0;
        valid_d   = 1'b0;
        state_d   = RUN;
      end
    end else if (state_q == RUN) begin
      acc_d     = step_acc;
      ovf_acc_d = ovf_acc_q | step_ovf;
      if (idx_q == '0) begin
        value_d = step_acc[W-1:0];
        ovf_d   = ovf_acc_q | step_ovf;
        valid_d = 1'b1;
        state_d = IDLE;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q  <= '0;
      count_q   <= '0;
      mode_q    <= mode;
      err_q     <= 1'b0;
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      ovf_acc_q <= 1'b0;
      value_q   <= '0;
      valid_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      digits_q  <= digits_d;
      count_q   <= count_d;
      mode_q    <= mode;
      err_q     <= err_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      ovf_acc_q <= ovf_acc_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign digits = digits_q;
  assign count  = count_q;
  assign value  = value_q;
  assign valid  = valid_q;
  assign busy   = (state_q == RUN);
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Self-checking bench: table of conversions plus hand-written edit/mode/reset sequences.
module tb_digit_entry_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        push, del, clr, mode;
  logic [3:0]  din;
  logic [15:0] digits, value;
  logic [2:0]  count;
  logic        valid, busy, ovf, err;

  logic        push5, del5, clr5, mode5;
  logic [3:0]  din5;
  logic [19:0] digits5;
  logic [15:0] value5;
  logic [2:0]  count5;
  logic        valid5, busy5, ovf5, err5;

  digit_entry_buffer #(.NDIG(4), .W(16)) dut (
    .clk(clk), .rst(rst), .push(push), .del(del), .clr(clr), .mode(mode), .din(din),
    .digits(digits), .count(count), .value(value), .valid(valid), .busy(busy), .ovf(ovf),
    .err(err)
  );

  digit_entry_buffer #(.NDIG(5), .W(16)) dut5 (
    .clk(clk), .rst(rst), .push(push5), .del(del5), .clr(clr5), .mode(mode5), .din(din5),
    .digits(digits5), .count(count5), .value(value5), .valid(valid5), .busy(busy5), .ovf(ovf5),
    .err(err5)
  );

  typedef struct {
    logic        mode;
    int          n;
    logic [15:0] dig;   // pushed MSD first; also the expected buffer
    logic [15:0] val;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] val;
    logic        ovf;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic p, input logic d, input logic c, input logic [3:0] v);
    push = p; del = d; clr = c; din = v;
    tick();
    push = 1'b0; del = 1'b0; clr = 1'b0;
  endtask

  task automatic pulse5(input logic p, input logic c, input logic [3:0] v);
    push5 = p; clr5 = c; din5 = v;
    tick();
    push5 = 1'b0; clr5 = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] v, input logic o);
    exp_t e;
    e.val = v;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Waits (bounded) for valid, then pops the scoreboard and compares value/ovf/latency.
  task automatic wait_result(input string name, input bit big, input int exp_lat);
    int   lat;
    logic v;
    exp_t e;
    lat = 0;
    v = big ? valid5 : valid;
    while (!v && lat < 40) begin
      tick();
      lat++;
      v = big ? valid5 : valid;
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if (!v) begin
      checks++; errors++;
      $display("FAIL %s: valid never rose within %0d cycles", name, lat);
      return;
    end
    chk({name, " value"}, big ? value5 : value, e.val);
    chk({name, " ovf"}, big ? ovf5 : ovf, e.ovf);
    if (exp_lat >= 0) chk({name, " latency"}, lat, exp_lat);
  endtask

  initial begin
    vecs[0] = '{mode: 1'b0, n: 4, dig: 16'h1A3F, val: 16'h1A3F, ovf: 1'b0};
    vecs[1] = '{mode: 1'b1, n: 4, dig: 16'h9999, val: 16'd9999, ovf: 1'b0};
    vecs[2] = '{mode: 1'b1, n: 3, dig: 16'h0123, val: 16'd123,  ovf: 1'b0};
    vecs[3] = '{mode: 1'b0, n: 4, dig: 16'hFFFF, val: 16'hFFFF, ovf: 1'b0};
    vecs[4] = '{mode: 1'b1, n: 3, dig: 16'h0007, val: 16'd7,    ovf: 1'b0};
    vecs[5] = '{mode: 1'b0, n: 1, dig: 16'h0005, val: 16'h0005, ovf: 1'b0};
    vecs[6] = '{mode: 1'b1, n: 4, dig: 16'h0800, val: 16'd800,  ovf: 1'b0};

    push = 0; del = 0; clr = 0; mode = 0; din = 0;
    push5 = 0; del5 = 0; clr5 = 0; mode5 = 1; din5 = 0;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("reset count", count, 0);
    chk("reset digits", digits, 0);
    chk("reset value", value, 0);
    chk("reset valid", valid, 1);
    chk("reset busy", busy, 0);
    chk("reset ovf", ovf, 0);
    chk("reset err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();

    // Table-driven conversions.
    for (int k = 0; k < 7; k++) begin
      mode = vecs[k].mode;
      pulse(0, 0, 1, 4'd0);
      chk($sformatf("vec%0d cleared", k), count, 0);
      for (int i = 0; i < vecs[k].n; i++) begin
        pulse(1, 0, 0, vecs[k].dig[4*(vecs[k].n-1-i) +: 4]);
      end
      push_exp(vecs[k].val, vecs[k].ovf);
      chk($sformatf("vec%0d busy", k), busy, 1);
      wait_result($sformatf("vec%0d", k), 1'b0, vecs[k].n);
      chk($sformatf("vec%0d count", k), count, vecs[k].n);
      chk($sformatf("vec%0d digits", k), digits, vecs[k].dig);
      chk($sformatf("vec%0d busy done", k), busy, 0);
    end

    // Decimal full buffer: push rejected, buffer and value untouched.
    mode = 1;
    pulse(0, 0, 1, 4'd0);
    for (int i = 0; i < 4; i++) pulse(1, 0, 0, 4'd9);
    push_exp(16'd9999, 1'b0);
    wait_result("dec9999", 1'b0, 4);
    pulse(1, 0, 0, 4'd5);
    chk("full err", err, 1);
    chk("full digits", digits, 16'h9999);
    chk("full count", count, 4);
    chk("full valid", valid, 1);
    chk("full value", value, 16'd9999);
    tick();
    chk("full err one cycle", err, 0);

    // Decimal digit reject and backspace on empty.
    pulse(0, 0, 1, 4'd0);
    pulse(1, 0, 0, 4'hC);
    chk("dec reject err", err, 1);
    chk("dec reject count", count, 0);
    pulse(0, 1, 0, 4'd0);
    chk("del empty err", err, 1);
    chk("del empty count", count, 0);

    // Edit priority: del beats push, clr beats both.
    mode = 0;
    pulse(1, 0, 0, 4'd1);
    pulse(1, 0, 0, 4'd2);
    push_exp(16'h0012, 1'b0);
    wait_result("hex12", 1'b0, 2);
    pulse(1, 1, 0, 4'd3);
    chk("del>push digits", digits, 16'h0001);
    chk("del>push err", err, 0);
    push_exp(16'h0001, 1'b0);
    wait_result("del>push", 1'b0, 1);
    pulse(1, 1, 1, 4'd3);
    chk("clr wins count", count, 0);
    chk("clr wins err", err, 0);
    chk("clr wins valid", valid, 1);
    chk("clr wins value", value, 0);

    // Mode switch reconverts the same digits in the new radix.
    pulse(1, 0, 0, 4'd1);
    pulse(1, 0, 0, 4'd2);
    push_exp(16'h0012, 1'b0);
    wait_result("sw hex", 1'b0, 2);
    mode = 1;
    tick();
    chk("sw dec err", err, 0);
    push_exp(16'd12, 1'b0);
    wait_result("sw dec", 1'b0, 2);
    mode = 0;
    tick();
    push_exp(16'h0012, 1'b0);
    wait_result("sw back hex", 1'b0, 2);

    // Switching to decimal with a hex digit held clears the buffer.
    pulse(0, 0, 1, 4'd0);
    pulse(1, 0, 0, 4'd1);
    pulse(1, 0, 0, 4'hB);
    push_exp(16'h001B, 1'b0);
    wait_result("hex1B", 1'b0, 2);
    mode = 1;
    tick();
    chk("sw clear err", err, 1);
    chk("sw clear count", count, 0);
    chk("sw clear digits", digits, 0);
    chk("sw clear valid", valid, 1);
    chk("sw clear value", value, 0);
    chk("sw clear busy", busy, 0);

    // Backspace on the second busy cycle restarts with three digits.
    mode = 0;
    pulse(0, 0, 1, 4'd0);
    for (int i = 1; i <= 4; i++) pulse(1, 0, 0, 4'(i));
    tick();
    pulse(0, 1, 0, 4'd0);
    chk("midrun valid low", valid, 0);
    push_exp(16'h0123, 1'b0);
    wait_result("midrun del", 1'b0, 3);
    chk("midrun digits", digits, 16'h0123);
    chk("midrun count", count, 3);

    // Rejected push while running leaves the conversion alone.
    pulse(1, 0, 0, 4'd4);
    tick();
    pulse(1, 0, 0, 4'd5);
    chk("run reject err", err, 1);
    push_exp(16'h1234, 1'b0);
    wait_result("run reject", 1'b0, 2);

    // Reset in the middle of a conversion.
    pulse(0, 0, 1, 4'd0);
    for (int i = 1; i <= 3; i++) pulse(1, 0, 0, 4'(i));
    #2 rst = 1'b0;
    #1;
    chk("midrst digits", digits, 0);
    chk("midrst count", count, 0);
    chk("midrst value", value, 0);
    chk("midrst valid", valid, 1);
    chk("midrst busy", busy, 0);
    chk("midrst ovf", ovf, 0);
    chk("midrst err", err, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("postrst valid", valid, 1);

    // Overflow boundary on the five-digit instance (decimal from reset).
    pulse5(0, 1, 4'd0);
    pulse5(1, 0, 4'd6);
    pulse5(1, 0, 4'd5);
    pulse5(1, 0, 4'd5);
    pulse5(1, 0, 4'd3);
    pulse5(1, 0, 4'd6);
    chk("ovf digits", digits5, 20'h65536);
    push_exp(16'd0, 1'b1);
    wait_result("ovf 65536", 1'b1, 5);
    pulse5(0, 1, 4'd0);
    chk("ovf cleared", ovf5, 0);
    pulse5(1, 0, 4'd6);
    pulse5(1, 0, 4'd5);
    pulse5(1, 0, 4'd5);
    pulse5(1, 0, 4'd3);
    pulse5(1, 0, 4'd5);
    push_exp(16'd65535, 1'b0);
    wait_result("max 65535", 1'b1, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
